kf8237_channel_arbiter: RTL

Parametrised DMA channel arbiter: the next-generation request/priority stage of the KF8237 DMA controller, scaled from a fixed 4 channels to `CHANNELS`. It combines hardware DREQ pins with software requests and per-channel masks, and selects one channel by fixed or rotating priority. It runs the HRQ/HLDA/DACK handshake and applies end-of-process side effects (clear the software request, auto-mask). It sits between the bus-control register decode and the address/count transfer engine.

---
 rtl/kf8237_channel_arbiter.sv | 211 +++++++++++++++++++++
 1 files changed

// File: rtl/kf8237_channel_arbiter.sv
// kf8237_channel_arbiter
// Request/priority stage of the KF8237 DMA controller, parametrised on channel
// count. It merges synchronised DREQ pins with software requests and masks,
// picks one channel by fixed or rotating priority and runs HRQ/HLDA/DACK.
//
// Ports:
//   clock, reset           system clock, async active-high reset
//   write_command          load command_data (b0 disable, b1 rotate, b2 DREQ low, b3 DACK high)
//   write_request          software request write (request_channel/request_value)
//   set_or_reset_mask      single mask bit write (mask_channel/mask_value)
//   write_mask, mask_data  full mask load
//   clear_mask             clear all masks
//   master_clear           synchronous soft reset
//   channel_autoinit       per-channel autoinit mode (suppresses EOP auto-mask)
//   dma_request            asynchronous DREQ pins
//   hold_acknowledge       HLDA
//   end_of_process         EOP / terminal count for the granted channel
//   service_release        end of service without EOP
//   hold_request           HRQ (registered)
//   dma_acknowledge        one-hot DACK, polarity from b3 (registered, resets to zero)
//   grant_valid            channel in service
//   active_channel         latched channel
//   request_status         effective pending requests (one cycle behind)
//   mask_status            mask register
module kf8237_channel_arbiter #(
  parameter int unsigned CHANNELS    = 4,
  parameter int unsigned CH_ID_WIDTH = 2
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   write_command,
  input  logic [3:0]             command_data,
  input  logic                   write_request,
  input  logic [CH_ID_WIDTH-1:0] request_channel,
  input  logic                   request_value,
  input  logic                   set_or_reset_mask,
  input  logic [CH_ID_WIDTH-1:0] mask_channel,
  input  logic                   mask_value,
  input  logic                   write_mask,
  input  logic [CHANNELS-1:0]    mask_data,
  input  logic                   clear_mask,
  input  logic                   master_clear,
  input  logic [CHANNELS-1:0]    channel_autoinit,
  input  logic [CHANNELS-1:0]    dma_request,
  input  logic                   hold_acknowledge,
  input  logic                   end_of_process,
  input  logic                   service_release,
  output logic                   hold_request,
  output logic [CHANNELS-1:0]    dma_acknowledge,
  output logic                   grant_valid,
  output logic [CH_ID_WIDTH-1:0] active_channel,
  output logic [CHANNELS-1:0]    request_status,
  output logic [CHANNELS-1:0]    mask_status
);

  localparam int unsigned SUM_W = CH_ID_WIDTH + 1;

  typedef enum logic [1:0] {ST_IDLE, ST_HOLD, ST_GRANT, ST_RELEASE} state_t;

  state_t                  state, state_n;
  logic [3:0]              cmd, cmd_n;
  logic [CHANNELS-1:0]     sync1, sync1_n, sync2, sync2_n;
  logic [CHANNELS-1:0]     mask, mask_n, sw_req, sw_req_n;
  logic [CH_ID_WIDTH-1:0]  prio, prio_n, chan, chan_n;
  logic [CHANNELS-1:0]     hw_req, pend;
  logic [CHANNELS-1:0]     dack_n, onehot, req_stat_n;
  logic                    hrq_n, gv_n, leave;

  logic [CH_ID_WIDTH-1:0]  base, off, winner;
  logic [2*CHANNELS-1:0]   pend2;
  logic [CHANNELS-1:0]     rot;
  logic [SUM_W-1:0]        sum;

  assign hw_req         = sync2 ^ {CHANNELS{cmd[2]}};
  assign pend           = (hw_req & ~mask) | sw_req;
  assign active_channel = chan;
  assign mask_status    = mask;

  // Winner: first pending channel at or after the priority base, wrapping.
  always_comb begin
    base  = cmd[1] ? prio : '0;
    pend2 = {pend, pend} >> base;
    rot   = pend2[CHANNELS-1:0];
    off   = '0;
    for (int i = int'(CHANNELS) - 1; i >= 0; i--) begin
      if (rot[i]) off = CH_ID_WIDTH'(i);
    end
    sum = {1'b0, base} + {1'b0, off};
    if (sum >= SUM_W'(CHANNELS)) winner = CH_ID_WIDTH'(sum - SUM_W'(CHANNELS));
    else                         winner = CH_ID_WIDTH'(sum);
  end

  // Next-state, register updates and registered-output values.
  always_comb begin
    state_n  = state;
    cmd_n    = cmd;
    chan_n   = chan;
    prio_n   = prio;
    mask_n   = mask;
    sw_req_n = sw_req;
    sync1_n  = dma_request;
    sync2_n  = sync1;
    leave    = 1'b0;

    unique case (state)
      ST_IDLE:    if (|pend && !cmd[0]) begin
                    chan_n  = winner;
                    state_n = ST_HOLD;
                  end
      ST_HOLD:    if (!pend[chan])           state_n = ST_RELEASE;
                  else if (hold_acknowledge) state_n = ST_GRANT;
      ST_GRANT:   if (end_of_process || service_release) begin
                    leave   = 1'b1;
                    state_n = ST_RELEASE;
                  end
      ST_RELEASE: if (!hold_acknowledge) state_n = ST_IDLE;
      default:    state_n = ST_IDLE;
    endcase

    if (write_mask)      mask_n = mask_data;
    else if (clear_mask) mask_n = '0;
    else if (set_or_reset_mask) begin
      for (int i = 0; i < int'(CHANNELS); i++) begin
        if (mask_channel == CH_ID_WIDTH'(i)) mask_n[i] = mask_value;
      end
    end

    if (write_request) begin
      for (int i = 0; i < int'(CHANNELS); i++) begin
        if (request_channel == CH_ID_WIDTH'(i)) sw_req_n[i] = request_value;
      end
    end

    // EOP side effects applied last so the auto-mask set wins over clears.
    if (leave && end_of_process) begin
      for (int i = 0; i < int'(CHANNELS); i++) begin
        if (chan == CH_ID_WIDTH'(i)) begin
          sw_req_n[i] = 1'b0;
          if (!channel_autoinit[i]) mask_n[i] = 1'b1;
        end
      end
    end

    if (leave && cmd[1])
      prio_n = (chan == CH_ID_WIDTH'(CHANNELS - 1)) ? '0 : chan + 1'b1;

    if (write_command) begin
      cmd_n  = command_data;
      prio_n = '0;
    end

    if (master_clear) begin
      state_n  = ST_IDLE;
      cmd_n    = '0;
      chan_n   = '0;
      prio_n   = '0;
      mask_n   = '1;
      sw_req_n = '0;
      sync1_n  = '0;
      sync2_n  = '0;
    end

    hrq_n = (state_n == ST_HOLD) || (state_n == ST_GRANT);
    gv_n  = (state_n == ST_GRANT);
    for (int i = 0; i < int'(CHANNELS); i++) begin
      onehot[i] = gv_n && (chan_n == CH_ID_WIDTH'(i));
    end
    dack_n     = cmd[3] ? onehot : ~onehot;
    req_stat_n = pend;
    if (master_clear) begin
      dack_n     = '0;
      req_stat_n = '0;
    end
  end

  // FSM state register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_n;
  end

  // Datapath and output registers.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cmd             <= '0;
      sync1           <= '0;
      sync2           <= '0;
      mask            <= '1;
      sw_req          <= '0;
      prio            <= '0;
      chan            <= '0;
      hold_request    <= 1'b0;
      grant_valid     <= 1'b0;
      dma_acknowledge <= '0;
      request_status  <= '0;
    end else begin
      cmd             <= cmd_n;
      sync1           <= sync1_n;
      sync2           <= sync2_n;
      mask            <= mask_n;
      sw_req          <= sw_req_n;
      prio            <= prio_n;
      chan            <= chan_n;
      hold_request    <= hrq_n;
      grant_valid     <= gv_n;
      dma_acknowledge <= dack_n;
      request_status  <= req_stat_n;
    end
  end

endmodule
